// File: rtl/tim_core_if.sv
// Register-field and status bundle between the AHB timer slave wrapper (master)
// and the counter engine (slave).
interface tim_core_if;
    logic        start;
    logic        irq_en;
    logic [1:0]  mode;
    logic [7:0]  psc;
    logic [15:0] arr;
    logic [15:0] tim_cnt;
    logic        tim_irq;
    logic        tim_busy;

    modport master (
        output start, irq_en, mode, psc, arr,
        input  tim_cnt, tim_irq, tim_busy
    );

    modport slave (
        input  start, irq_en, mode, psc, arr,
        output tim_cnt, tim_irq, tim_busy
    );
endinterface

// File: rtl/tim_core.sv
// tim_core: prescaler, 16-bit counter and IDLE/RUN/DONE control of the AHB timer.
// Define TIM_PRELOAD_EN to shadow psc/arr, reloaded at start and on every update event.
module tim_core (
    input logic       HCLK,
    input logic       HRESET,
    tim_core_if.slave tif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {M_UP, M_DOWN, M_ONESHOT, M_CENTRE} mode_t;

    state_t      state;
    mode_t       mode_q;
    logic [7:0]  psc_cnt;
    logic [15:0] cnt_q;
    logic        irq_q;
    logic        busy_q;
    logic        dir_up;

    logic [7:0]  psc_act;
    logic [15:0] arr_act;

    logic        tick;
    logic        upd;
    logic        hit_end;
    logic        dir_nxt;
    logic [15:0] cnt_nxt;

`ifdef TIM_PRELOAD_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            psc_act <= '0;
            arr_act <= '0;
        end else if (tif.start && (state == IDLE || (state == RUN && upd))) begin
            psc_act <= tif.psc;
            arr_act <= tif.arr;
        end
    end
`else
    assign psc_act = tif.psc;
    assign arr_act = tif.arr;
`endif

    // Next count and update event for the current tick; only consumed in RUN.
    always_comb begin
        tick    = (psc_cnt >= psc_act);
        upd     = 1'b0;
        hit_end = 1'b0;
        cnt_nxt = cnt_q;
        dir_nxt = dir_up;
        if (tick) begin
            case (mode_q)
                M_UP: begin
                    if (cnt_q >= arr_act) begin
                        cnt_nxt = '0;
                        upd     = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + 16'd1;
                    end
                end
                M_DOWN: begin
                    if (cnt_q > arr_act) begin
                        cnt_nxt = arr_act;
                    end else if (cnt_q == 16'd0) begin
                        cnt_nxt = arr_act;
                        upd     = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q - 16'd1;
                    end
                end
                M_ONESHOT: begin
                    if (cnt_q >= arr_act) begin
                        cnt_nxt = arr_act;
                        upd     = 1'b1;
                        hit_end = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + 16'd1;
                    end
                end
                M_CENTRE: begin
                    if (arr_act == 16'd0) begin
                        cnt_nxt = '0;
                        upd     = 1'b1;
                        dir_nxt = 1'b1;
                    end else if (dir_up) begin
                        if (cnt_q >= arr_act) begin
                            cnt_nxt = cnt_q - 16'd1;
                            upd     = 1'b1;
                            dir_nxt = 1'b0;
                        end else begin
                            cnt_nxt = cnt_q + 16'd1;
                        end
                    end else if (cnt_q <= 16'd1) begin
                        cnt_nxt = '0;
                        upd     = 1'b1;
                        dir_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q - 16'd1;
                    end
                end
            endcase
        end
    end

    // Dropping start aborts from any state without generating an update.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= IDLE;
            mode_q  <= M_UP;
            psc_cnt <= '0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
            dir_up  <= 1'b1;
        end else if (!tif.start) begin
            state   <= IDLE;
            psc_cnt <= '0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
            dir_up  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state   <= RUN;
                    mode_q  <= mode_t'(tif.mode);
                    psc_cnt <= '0;
                    cnt_q   <= (tif.mode == 2'b01) ? tif.arr : 16'd0;
                    irq_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    dir_up  <= 1'b1;
                end
                RUN: begin
                    psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
                    irq_q   <= upd & tif.irq_en;
                    cnt_q   <= cnt_nxt;
                    dir_up  <= dir_nxt;
                    if (hit_end) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    irq_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign tif.tim_cnt  = cnt_q;
    assign tif.tim_irq  = irq_q;
    assign tif.tim_busy = busy_q;
endmodule

// File: tb/tb_tim_core.sv
// Directed self-checking bench for tim_core; expected values are hand-derived.
// Build with TIM_PRELOAD_EN defined to check the shadow-register variant.
module tb_tim_core;
    logic HCLK;
    logic HRESET;
    int   total;
    int   bad;

    tim_core_if tif ();

    tim_core dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .tif    (tif)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        tif.start = 1'b0; tif.irq_en = 1'b0; tif.mode = 2'b00;
        tif.psc = 8'd0; tif.arr = 16'd0;
        step(); step();
        total++;
        if (tif.tim_cnt !== 16'd0 || tif.tim_irq !== 1'b0 || tif.tim_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset: cnt=%0d irq=%b busy=%b want 0/0/0", tif.tim_cnt, tif.tim_irq, tif.tim_busy);
        end
        HRESET = 1'b0;
        step();
    endtask

    task automatic test_up();
        tif.psc = 8'd0; tif.arr = 16'd3; tif.mode = 2'b00; tif.irq_en = 1'b1; tif.start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            total++;
            if (tif.tim_cnt !== 16'(i % 4) || tif.tim_irq !== (i > 0 && i % 4 == 0) || tif.tim_busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL up[%0d]: cnt=%0d irq=%b busy=%b want %0d/%b/1", i, tif.tim_cnt, tif.tim_irq,
                         tif.tim_busy, i % 4, (i > 0 && i % 4 == 0));
            end
        end
        tif.start = 1'b0;
        step();
    endtask

    task automatic test_down();
        logic exp_irq;
        tif.psc = 8'd2; tif.arr = 16'd2; tif.mode = 2'b01; tif.irq_en = 1'b1; tif.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            exp_irq = (i > 0) && (i % 9 == 0) && (i < 20);
            total++;
            if (tif.tim_cnt !== 16'(2 - ((i / 3) % 3)) || tif.tim_irq !== exp_irq) begin
                bad++;
                $display("[TB] FAIL down[%0d]: cnt=%0d irq=%b want %0d/%b", i, tif.tim_cnt, tif.tim_irq,
                         2 - ((i / 3) % 3), exp_irq);
            end
            if (i == 19) tif.irq_en = 1'b0;
        end
        tif.start = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        int pulses;
        pulses = 0;
        tif.psc = 8'd0; tif.arr = 16'd5; tif.mode = 2'b10; tif.irq_en = 1'b1; tif.start = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            if (tif.tim_irq === 1'b1) pulses++;
            total++;
            if (tif.tim_cnt !== 16'((i <= 5) ? i : 5) || tif.tim_irq !== (i == 6) || tif.tim_busy !== (i < 6)) begin
                bad++;
                $display("[TB] FAIL oneshot[%0d]: cnt=%0d irq=%b busy=%b want %0d/%b/%b", i, tif.tim_cnt,
                         tif.tim_irq, tif.tim_busy, (i <= 5) ? i : 5, (i == 6), (i < 6));
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("[TB] FAIL oneshot_pulses: got %0d want 1", pulses);
        end
        tif.start = 1'b0;
        step();
        total++;
        if (tif.tim_cnt !== 16'd0 || tif.tim_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL oneshot_drop: cnt=%0d busy=%b want 0/0", tif.tim_cnt, tif.tim_busy);
        end
        tif.start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            total++;
            if (tif.tim_cnt !== 16'((i <= 5) ? i : 5) || tif.tim_irq !== (i == 6)) begin
                bad++;
                $display("[TB] FAIL oneshot_restart[%0d]: cnt=%0d irq=%b want %0d/%b", i, tif.tim_cnt,
                         tif.tim_irq, (i <= 5) ? i : 5, (i == 6));
            end
        end
        tif.start = 1'b0;
        step();
    endtask

    task automatic test_centre();
        int   exp_cnt [11] = '{0, 1, 2, 1, 0, 1, 2, 1, 0, 1, 2};
        logic exp_irq [11] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
        tif.psc = 8'd0; tif.arr = 16'd2; tif.mode = 2'b11; tif.irq_en = 1'b1; tif.start = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            total++;
            if (tif.tim_cnt !== 16'(exp_cnt[i]) || tif.tim_irq !== exp_irq[i]) begin
                bad++;
                $display("[TB] FAIL centre[%0d]: cnt=%0d irq=%b want %0d/%b", i, tif.tim_cnt, tif.tim_irq,
                         exp_cnt[i], exp_irq[i]);
            end
        end
        tif.start = 1'b0;
        step();
    endtask

    task automatic test_reload_change();
`ifdef TIM_PRELOAD_EN
        int   exp_cnt [9] = '{6, 7, 8, 9, 0, 1, 2, 3, 0};
        logic exp_irq [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
`else
        int   exp_cnt [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        logic exp_irq [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
`endif
        tif.psc = 8'd0; tif.arr = 16'd9; tif.mode = 2'b00; tif.irq_en = 1'b1; tif.start = 1'b1;
        for (int i = 0; i < 6; i++) step();
        total++;
        if (tif.tim_cnt !== 16'd5) begin
            bad++;
            $display("[TB] FAIL reload_pre: cnt=%0d want 5", tif.tim_cnt);
        end
        tif.arr = 16'd3;
        for (int i = 0; i < 9; i++) begin
            step();
            total++;
            if (tif.tim_cnt !== 16'(exp_cnt[i]) || tif.tim_irq !== exp_irq[i]) begin
                bad++;
                $display("[TB] FAIL reload[%0d]: cnt=%0d irq=%b want %0d/%b", i, tif.tim_cnt, tif.tim_irq,
                         exp_cnt[i], exp_irq[i]);
            end
        end
        tif.start = 1'b0;
        step();
    endtask

    task automatic test_abort();
        tif.psc = 8'd0; tif.arr = 16'd20; tif.mode = 2'b00; tif.irq_en = 1'b1; tif.start = 1'b1;
        for (int i = 0; i < 8; i++) step();
        total++;
        if (tif.tim_cnt !== 16'd7) begin
            bad++;
            $display("[TB] FAIL abort_pre: cnt=%0d want 7", tif.tim_cnt);
        end
        tif.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (tif.tim_cnt !== 16'd0 || tif.tim_busy !== 1'b0 || tif.tim_irq !== 1'b0) begin
                bad++;
                $display("[TB] FAIL abort[%0d]: cnt=%0d busy=%b irq=%b want 0/0/0", i, tif.tim_cnt,
                         tif.tim_busy, tif.tim_irq);
            end
        end
    endtask

    task automatic test_back_to_back();
        tif.psc = 8'd0; tif.arr = 16'd3; tif.mode = 2'b00; tif.irq_en = 1'b1; tif.start = 1'b1;
        for (int i = 0; i < 4; i++) step();
        tif.start = 1'b0;
        step();
        tif.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (tif.tim_cnt !== 16'(i % 4) || tif.tim_irq !== (i == 4) || tif.tim_busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL b2b[%0d]: cnt=%0d irq=%b busy=%b want %0d/%b/1", i, tif.tim_cnt,
                         tif.tim_irq, tif.tim_busy, i % 4, (i == 4));
            end
        end
        tif.start = 1'b0;
        step();
    endtask

    task automatic test_reset_midrun();
        tif.psc = 8'd0; tif.arr = 16'd3; tif.mode = 2'b00; tif.irq_en = 1'b1; tif.start = 1'b1;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (tif.tim_cnt !== 16'd3) begin
            bad++;
            $display("[TB] FAIL rst_mid_pre: cnt=%0d want 3", tif.tim_cnt);
        end
        HRESET = 1'b1;
        step();
        total++;
        if (tif.tim_cnt !== 16'd0 || tif.tim_irq !== 1'b0 || tif.tim_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid: cnt=%0d irq=%b busy=%b want 0/0/0", tif.tim_cnt, tif.tim_irq, tif.tim_busy);
        end
        HRESET = 1'b0;
        tif.start = 1'b0;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_up();
        test_down();
        test_oneshot();
        test_centre();
        test_reload_change();
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tim_core.md
# tim_core

Counter engine of the AHB timer peripheral. Consumes the decoded register fields (start, interrupt enable, mode, prescaler, auto-reload) from the AHB slave wrapper. Returns the live 16-bit count for the status register and a one-cycle interrupt pulse. Contains the prescaler, the main counter, the run/halt state machine and optional shadow (preload) registers.

## Interface
Parameters:
- none; all widths are fixed (psc 8 b, arr/cnt 16 b).

Ports:
- `HCLK` in 1: system clock. One clock domain only.
- `HRESET` in 1: reset, synchronous, active-high.
- `start` in 1: run enable. Level-sensitive.
- `irq_en` in 1: enables `tim_irq` pulses.
- `mode` in 2: 00 up, 01 down, 10 one-shot up, 11 up/down (centre).
- `psc` in 8: prescaler. Counter tick rate = HCLK/(psc+1).
- `arr` in 16: auto-reload / terminal value.
- `tim_cnt` out 16: current counter value, registered.
- `tim_irq` out 1: one-cycle pulse per update event when `irq_en`=1, registered.
- `tim_busy` out 1: high while in RUN.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE to RUN: on the edge where `start`=1. At that edge:
    - `mode` is latched into `mode_q`;
    - the prescaler count is cleared;
    - `tim_cnt` loads 0, or `arr_act` when `mode`=01;
    - the centre-mode direction is set to up.
  - RUN to DONE: on the one-shot terminal update.
  - Any state to IDLE: on any edge where `start`=0. `tim_cnt` becomes 0, the prescaler clears, and no update event is generated.
  - DONE holds `tim_cnt` until `start`=0. Restarting requires dropping `start` for at least one cycle.
- Mode changes during RUN are ignored. `mode_q` is fixed until the next IDLE to RUN.
- Prescaler:
  - `psc_cnt` increments every cycle in RUN.
  - When `psc_cnt`>=`psc_act`, a tick is produced and `psc_cnt` returns to 0.
  - With `psc`=0 there is a tick every cycle.
- Counter action on each tick:
  - **Up (00):** if `tim_cnt`>=`arr_act`, then `tim_cnt`=0 and an update event occurs; otherwise `tim_cnt`+1.
  - **Down (01):** if `tim_cnt`==0, then `tim_cnt`=`arr_act` and an update event occurs; otherwise `tim_cnt`-1. Additionally, if `tim_cnt`>`arr_act`, the counter reloads `arr_act` without an update.
  - **One-shot (10):**
    - Counts as up mode.
    - At `tim_cnt`>=`arr_act`: update event, `tim_cnt` holds `arr_act`, go to DONE.
  - **Centre (11):**
    - While counting up: at `tim_cnt`>=`arr_act`, update, direction becomes down, `tim_cnt`-1.
    - While counting down: at `tim_cnt`==1, `tim_cnt`=0, update, direction becomes up.
    - With `arr_act`=0: `tim_cnt` stays 0 and every tick is an update.
- `arr_act`=0 in up, down or one-shot mode: every tick is an update and `tim_cnt` stays 0.
- All arithmetic is 16-bit unsigned. No overflow is reachable because every compare uses >=.
- Each update event produces `tim_irq`=1 for exactly one cycle if `irq_en`=1 at that edge. No pulse is ever produced from IDLE.

## Timing
- Reset values (all at the `HRESET` edge):
  - `tim_cnt`=0, `tim_irq`=0, `tim_busy`=0;
  - state IDLE, `psc_cnt`=0, direction up;
  - shadow `psc`/`arr`=0.
- `HRESET` takes priority over all other inputs, including mid-run.
- Start latency:
  - `start` is sampled high at edge k.
  - `tim_busy`=1 and `tim_cnt` holds its load value after edge k.
  - The first tick is at edge k+1+`psc`.
- `tim_irq` is asserted after the same edge at which the counter reloads or turns around, and deasserted after the next edge.
- Update period:
  - Up/down modes: (`arr`+1)·(`psc`+1) cycles.
  - Centre mode: 2·`arr`·(`psc`+1) cycles between turnarounds of the same kind.
- `start` dropped and re-raised within one cycle: the restart is clean, with no update event.

## Configuration
- `TIM_PRELOAD_EN` defined:
  - `psc_act`/`arr_act` are shadow registers.
  - They load from `psc`/`arr` at IDLE to RUN and at every update event.
  - Input changes between updates have no effect on the current period.
- Undefined:
  - `psc_act`=`psc` and `arr_act`=`arr` combinationally.
  - Changes take effect on the next compare, handled by the >= rules.
  - No shadow flops are instantiated.

## Test plan
- **Up mode:** `psc`=0, `arr`=3, `mode`=00, `irq_en`=1, `start`=1. Required: `tim_cnt` 0,1,2,3,0,…; `tim_irq` pulses every 4 cycles, coincident with `tim_cnt` returning to 0; `tim_busy`=1.
- **Down mode:** `psc`=2, `arr`=2, `mode`=01. Required: `tim_cnt` 2,1,0,2, changing every 3 cycles; `tim_irq` every 9 cycles. With `irq_en`=0, no pulses occur.
- **One-shot:** `arr`=5, `mode`=10, `psc`=0. Required: exactly one `tim_irq`; `tim_cnt` holds 5; `tim_busy`=0. Then `start` low 1 cycle and high again: `tim_cnt` restarts from 0 and a second pulse occurs 6 cycles later.
- **Centre mode:** `arr`=2, `mode`=11, `psc`=0. Required: `tim_cnt` 0,1,2,1,0,1,2; `tim_irq` at each 2 and at each return to 0.
- **Reload change mid-run:** `arr`=9 in up mode, set `arr`=3 when `tim_cnt`=5.
  - With `TIM_PRELOAD_EN`: wraps at 9, then at 3.
  - Without: reloads to 0 on the next tick.
- **Abort and reset:**
  - `start` dropped at `tim_cnt`=7: required `tim_cnt`=0, `tim_busy`=0 next cycle, no pulse.
  - `HRESET` asserted mid-run: required all outputs 0 after that edge.
